// File: rtl/rram_seq_pkg.sv
// rtl/rram_seq_pkg.sv - opcodes, driver line codes and sequencer states shared by the RRAM sequencer
package rram_seq_pkg;

   localparam logic [3:0] OP_NOP    = 4'd0;
   localparam logic [3:0] OP_WRITE  = 4'd1;
   localparam logic [3:0] OP_READ   = 4'd2;
   localparam logic [3:0] OP_MAC    = 4'd3;
   localparam logic [3:0] OP_CONF_T = 4'd4;
   localparam logic [3:0] OP_CONF_V = 4'd5;

   // Driver codes are {IN1,IN0}
   localparam logic [1:0] LC_IDLE = 2'b11;
   localparam logic [1:0] LC_WR   = 2'b00;
   localparam logic [1:0] LC_RD   = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR_PULSE,
      ST_RD_PRE,
      ST_RD_SENSE,
      ST_MAC_PRE,
      ST_MAC_CONV,
      ST_DONE
   } seq_state_t;

endpackage

// File: rtl/rram_line_encoder.sv
// rtl/rram_line_encoder.sv - maps sequencer state and addresses onto per-line WL/SL/BL driver codes
module rram_line_encoder
   import rram_seq_pkg::*;
#(
   parameter int ARRAY_SIZE = 16,
   parameter int AW         = $clog2(ARRAY_SIZE)
) (
   input  seq_state_t            state,
   input  logic [AW-1:0]         row,
   input  logic [AW-1:0]         col,
   input  logic [1:0]            v_op,
   input  logic [AW:0]           grp_lo,
   input  logic [AW:0]           grp_hi,
   output logic [ARRAY_SIZE-1:0] in0_wl,
   output logic [ARRAY_SIZE-1:0] in1_wl,
   output logic [ARRAY_SIZE-1:0] in0_sl,
   output logic [ARRAY_SIZE-1:0] in1_sl,
   output logic [ARRAY_SIZE-1:0] in0_bl,
   output logic [ARRAY_SIZE-1:0] in1_bl
);

   logic [1:0] wl_code [ARRAY_SIZE];
   logic [1:0] sl_code [ARRAY_SIZE];
   logic [1:0] bl_code [ARRAY_SIZE];

   always_comb begin
      for (int i = 0; i < ARRAY_SIZE; i++) begin
         wl_code[i] = LC_IDLE;
         sl_code[i] = LC_IDLE;
         bl_code[i] = LC_IDLE;
      end
      case (state)
         ST_WR_PULSE: begin
            wl_code[row] = LC_WR;
            // V_OP=1 is RESET (SL side), everything else SETs from the BL side
            if (v_op == 2'd1) sl_code[col] = LC_WR;
            else              bl_code[col] = LC_WR;
         end
         ST_RD_PRE, ST_RD_SENSE: begin
            bl_code[col] = LC_RD;
            sl_code[col] = LC_WR;
            wl_code[row] = LC_WR;
         end
         ST_MAC_CONV: begin
            for (int i = 0; i < ARRAY_SIZE; i++) begin
               bl_code[i] = LC_RD;
               if ((AW+1)'(i) >= grp_lo && (AW+1)'(i) <= grp_hi) wl_code[i] = LC_WR;
            end
         end
         default: ;
      endcase
   end

   for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_split
      assign in0_wl[i] = wl_code[i][0];
      assign in1_wl[i] = wl_code[i][1];
      assign in0_sl[i] = sl_code[i][0];
      assign in1_sl[i] = sl_code[i][1];
      assign in0_bl[i] = bl_code[i][0];
      assign in1_bl[i] = bl_code[i][1];
   end

endmodule

// File: rtl/rram_op_sequencer.sv
// rtl/rram_op_sequencer.sv - RRAM array instruction sequencer: timed write, precharge/sense read, grouped MAC
module rram_op_sequencer
   import rram_seq_pkg::*;
#(
   parameter int  ARRAY_SIZE = 16,
   parameter int  MUX_WIDTH  = 8,
   parameter int  MAC_GROUP  = 4,
   parameter int  SENSE_CYC  = 2,
   parameter int  ADC_CYC    = 4,
   localparam int NUM_MUX    = ARRAY_SIZE / MUX_WIDTH,
   localparam int AW         = $clog2(ARRAY_SIZE),
   localparam int SW         = $clog2(MUX_WIDTH)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    instr_valid,
   output logic                    instr_ready,
   input  logic [31:0]             instruction,
   output logic [ARRAY_SIZE-1:0]   IN0_BL,
   output logic [ARRAY_SIZE-1:0]   IN1_BL,
   output logic [ARRAY_SIZE-1:0]   IN0_SL,
   output logic [ARRAY_SIZE-1:0]   IN1_SL,
   output logic [ARRAY_SIZE-1:0]   IN0_WL,
   output logic [ARRAY_SIZE-1:0]   IN1_WL,
   output logic                    ENABLE_WL,
   output logic                    ENABLE_SL,
   output logic                    ENABLE_BL,
   output logic [NUM_MUX*SW-1:0]   S_MUX,
   output logic [NUM_MUX-1:0]      SEL_TO_CSA,
   output logic [NUM_MUX-1:0]      SEL_TO_ADC,
   output logic                    PRE,
   output logic [NUM_MUX-1:0]      SAEN_CSA,
   output logic [NUM_MUX-1:0]      CLK_EN_ADC,
   output logic                    done,
   output logic                    err
);

   localparam int          KW         = (AW > SW) ? AW - SW : 1;
   localparam logic [7:0]  SENSE_LAST = 8'(SENSE_CYC - 1);
   localparam logic [7:0]  ADC_LAST   = 8'(ADC_CYC - 1);
   localparam logic [AW:0] GRP_STEP   = (AW+1)'(MAC_GROUP);

   seq_state_t    state;
   logic [7:0]    cnt;
   logic [7:0]    t_mult;
   logic [1:0]    v_op;
   logic [AW-1:0] row_q;
   logic [AW-1:0] col_q;
   logic [AW:0]   grp;
   logic [AW:0]   grp_next;
   logic [AW:0]   grp_last;
   logic [AW:0]   grp_hi;
   logic [KW-1:0] mux_k;
   logic [3:0]    opcode;
   logic          mac_bad;
   logic          instr_unused;

   assign opcode       = instruction[31:28];
   assign mac_bad      = instruction[2*AW-1:AW] < instruction[AW-1:0];
   assign instr_unused = ^instruction;
   assign instr_ready  = (state == ST_IDLE);

   // Group arithmetic is one bit wider so stepping past the last row never wraps
   assign grp_next = grp + GRP_STEP;
   assign grp_last = grp_next - (AW+1)'(1);
   assign grp_hi   = (grp_last > {1'b0, row_q}) ? {1'b0, row_q} : grp_last;
   assign mux_k    = KW'(col_q >> SW);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         t_mult <= '0;
         v_op   <= '0;
         row_q  <= '0;
         col_q  <= '0;
         grp    <= '0;
         done   <= 1'b0;
         err    <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            ST_IDLE: if (instr_valid) begin
               row_q <= instruction[2*AW-1:AW];
               col_q <= instruction[AW-1:0];
               cnt   <= '0;
               case (opcode)
                  OP_NOP:    begin state <= ST_DONE; done <= 1'b1; end
                  OP_CONF_T: begin t_mult <= instruction[7:0]; state <= ST_DONE; done <= 1'b1; end
                  OP_CONF_V: begin v_op <= instruction[1:0]; state <= ST_DONE; done <= 1'b1; end
                  OP_WRITE:  state <= ST_WR_PULSE;
                  OP_READ:   state <= ST_RD_PRE;
                  OP_MAC: begin
                     if (mac_bad) err <= 1'b1;
                     else begin
                        grp   <= {1'b0, instruction[AW-1:0]};
                        state <= ST_MAC_PRE;
                     end
                  end
                  default:   err <= 1'b1;
               endcase
            end
            ST_WR_PULSE: begin
               if (cnt == t_mult) begin state <= ST_DONE; done <= 1'b1; end
               else cnt <= cnt + 8'd1;
            end
            ST_RD_PRE: begin
               cnt   <= '0;
               state <= ST_RD_SENSE;
            end
            ST_RD_SENSE: begin
               if (cnt == SENSE_LAST) begin state <= ST_DONE; done <= 1'b1; end
               else cnt <= cnt + 8'd1;
            end
            ST_MAC_PRE: begin
               cnt   <= '0;
               state <= ST_MAC_CONV;
            end
            ST_MAC_CONV: begin
               if (cnt != ADC_LAST) cnt <= cnt + 8'd1;
               else if (grp_next > {1'b0, row_q}) begin state <= ST_DONE; done <= 1'b1; end
               else begin
                  grp   <= grp_next;
                  state <= ST_MAC_PRE;
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      ENABLE_WL  = 1'b0;
      ENABLE_SL  = 1'b0;
      ENABLE_BL  = 1'b0;
      S_MUX      = '0;
      SEL_TO_CSA = '0;
      SEL_TO_ADC = '0;
      PRE        = 1'b1;
      SAEN_CSA   = '0;
      CLK_EN_ADC = '0;
      case (state)
         ST_WR_PULSE: begin
            ENABLE_WL = 1'b1;
            ENABLE_SL = 1'b1;
            ENABLE_BL = 1'b1;
         end
         ST_RD_PRE: begin
            PRE                          = 1'b0;
            S_MUX[int'(mux_k)*SW +: SW]  = col_q[SW-1:0];
            SEL_TO_CSA[mux_k]            = 1'b1;
         end
         ST_RD_SENSE: begin
            ENABLE_WL                    = 1'b1;
            ENABLE_BL                    = 1'b1;
            S_MUX[int'(mux_k)*SW +: SW]  = col_q[SW-1:0];
            SEL_TO_CSA[mux_k]            = 1'b1;
            if (cnt == SENSE_LAST) SAEN_CSA[mux_k] = 1'b1;
         end
         ST_MAC_PRE: PRE = 1'b0;
         ST_MAC_CONV: begin
            ENABLE_WL  = 1'b1;
            ENABLE_BL  = 1'b1;
            SEL_TO_ADC = '1;
            CLK_EN_ADC = '1;
         end
         default: ;
      endcase
   end

   rram_line_encoder #(
      .ARRAY_SIZE (ARRAY_SIZE),
      .AW         (AW)
   ) u_line_encoder (
      .state  (state),
      .row    (row_q),
      .col    (col_q),
      .v_op   (v_op),
      .grp_lo (grp),
      .grp_hi (grp_hi),
      .in0_wl (IN0_WL),
      .in1_wl (IN1_WL),
      .in0_sl (IN0_SL),
      .in1_sl (IN1_SL),
      .in0_bl (IN0_BL),
      .in1_bl (IN1_BL)
   );

endmodule

// File: tb/tb_rram_op_sequencer.sv
// tb/tb_rram_op_sequencer.sv - bench for rram_op_sequencer with a cycle-trace reference model
module tb_rram_op_sequencer;

   localparam int N = 16, MW = 8, NM = 2, SWB = 3, GRP = 4, SENSE = 2, ADC = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              instr_valid;
   logic              instr_ready;
   logic [31:0]       instruction;
   logic [N-1:0]      IN0_BL, IN1_BL, IN0_SL, IN1_SL, IN0_WL, IN1_WL;
   logic              ENABLE_WL, ENABLE_SL, ENABLE_BL;
   logic [NM*SWB-1:0] S_MUX;
   logic [NM-1:0]     SEL_TO_CSA, SEL_TO_ADC, SAEN_CSA, CLK_EN_ADC;
   logic              PRE, done, err;

   always #5 clk = ~clk;

   rram_op_sequencer #(
      .ARRAY_SIZE(N), .MUX_WIDTH(MW), .MAC_GROUP(GRP), .SENSE_CYC(SENSE), .ADC_CYC(ADC)
   ) dut (
      .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instruction(instruction),
      .IN0_BL(IN0_BL), .IN1_BL(IN1_BL), .IN0_SL(IN0_SL), .IN1_SL(IN1_SL),
      .IN0_WL(IN0_WL), .IN1_WL(IN1_WL),
      .ENABLE_WL(ENABLE_WL), .ENABLE_SL(ENABLE_SL), .ENABLE_BL(ENABLE_BL),
      .S_MUX(S_MUX), .SEL_TO_CSA(SEL_TO_CSA), .SEL_TO_ADC(SEL_TO_ADC), .PRE(PRE),
      .SAEN_CSA(SAEN_CSA), .CLK_EN_ADC(CLK_EN_ADC), .done(done), .err(err)
   );

   typedef struct packed {
      logic [N-1:0]      in0_bl, in1_bl, in0_sl, in1_sl, in0_wl, in1_wl;
      logic              en_wl, en_sl, en_bl;
      logic [NM*SWB-1:0] s_mux;
      logic [NM-1:0]     sel_csa, sel_adc, saen, clken;
      logic              pre, done, err, ready;
   } snap_t;

   snap_t exp_q[$];
   int    n_checks = 0;
   int    n_fail   = 0;
   int    m_t      = 0;
   int    m_v      = 0;

   function automatic snap_t observe();
      snap_t s;
      s.in0_bl = IN0_BL; s.in1_bl = IN1_BL; s.in0_sl = IN0_SL; s.in1_sl = IN1_SL;
      s.in0_wl = IN0_WL; s.in1_wl = IN1_WL;
      s.en_wl = ENABLE_WL; s.en_sl = ENABLE_SL; s.en_bl = ENABLE_BL;
      s.s_mux = S_MUX; s.sel_csa = SEL_TO_CSA; s.sel_adc = SEL_TO_ADC;
      s.saen = SAEN_CSA; s.clken = CLK_EN_ADC;
      s.pre = PRE; s.done = done; s.err = err; s.ready = instr_ready;
      return s;
   endfunction

   function automatic snap_t idle_snap(input logic rdy);
      snap_t s = '0;
      s.in0_bl = '1; s.in1_bl = '1; s.in0_sl = '1; s.in1_sl = '1; s.in0_wl = '1; s.in1_wl = '1;
      s.pre = 1'b1;
      s.ready = rdy;
      return s;
   endfunction

   // Expected per-cycle trace after the accept edge, derived from the operation's phase rules
   function automatic void model(input logic [31:0] ins);
      snap_t s;
      int op  = int'(ins[31:28]);
      int col = int'(ins[3:0]);
      int row = int'(ins[7:4]);
      int k   = col / MW;
      case (op)
         0: ;
         4: m_t = int'(ins[7:0]);
         5: m_v = int'(ins[1:0]);
         1: for (int c = 0; c <= m_t; c++) begin
               s = idle_snap(1'b0);
               s.en_wl = 1'b1; s.en_sl = 1'b1; s.en_bl = 1'b1;
               s.in0_wl[row] = 1'b0; s.in1_wl[row] = 1'b0;
               if (m_v == 1) begin s.in0_sl[col] = 1'b0; s.in1_sl[col] = 1'b0; end
               else          begin s.in0_bl[col] = 1'b0; s.in1_bl[col] = 1'b0; end
               exp_q.push_back(s);
            end
         2: for (int c = 0; c <= SENSE; c++) begin
               s = idle_snap(1'b0);
               s.in0_bl[col] = 1'b0;
               s.in0_sl[col] = 1'b0; s.in1_sl[col] = 1'b0;
               s.in0_wl[row] = 1'b0; s.in1_wl[row] = 1'b0;
               s.s_mux[k*SWB +: SWB] = 3'(col % MW);
               s.sel_csa[k] = 1'b1;
               if (c == 0) s.pre = 1'b0;
               else begin
                  s.en_wl = 1'b1; s.en_bl = 1'b1;
                  if (c == SENSE) s.saen[k] = 1'b1;
               end
               exp_q.push_back(s);
            end
         3: begin
            if (row < col) begin
               s = idle_snap(1'b1); s.err = 1'b1;
               exp_q.push_back(s);
               exp_q.push_back(idle_snap(1'b1));
               return;
            end
            for (int g = col; g <= row; g += GRP) begin
               s = idle_snap(1'b0); s.pre = 1'b0;
               exp_q.push_back(s);
               for (int c = 0; c < ADC; c++) begin
                  s = idle_snap(1'b0);
                  s.en_wl = 1'b1; s.en_bl = 1'b1;
                  s.in0_bl = '0; s.sel_adc = '1; s.clken = '1;
                  for (int r = g; r <= row && r < g + GRP; r++) begin
                     s.in0_wl[r] = 1'b0; s.in1_wl[r] = 1'b0;
                  end
                  exp_q.push_back(s);
               end
            end
         end
         default: begin
            s = idle_snap(1'b1); s.err = 1'b1;
            exp_q.push_back(s);
            exp_q.push_back(idle_snap(1'b1));
            return;
         end
      endcase
      s = idle_snap(1'b0); s.done = 1'b1;
      exp_q.push_back(s);
      exp_q.push_back(idle_snap(1'b1));
   endfunction

   // Called at a falling edge with the sequencer idle; returns on the first post-accept falling edge
   task automatic issue(input logic [31:0] ins);
      model(ins);
      instruction = ins;
      instr_valid = 1'b1;
      @(negedge clk);
      instr_valid = 1'b0;
   endtask

   task automatic test_reset();
      snap_t obs;
      rst = 1'b1; instr_valid = 1'b0; instruction = '0;
      repeat (2) @(negedge clk);
      obs = observe(); n_checks++;
      if (obs !== idle_snap(1'b1)) begin n_fail++; $display("FAIL reset_state: got %h want %h", obs, idle_snap(1'b1)); end
      rst = 1'b0;
      @(negedge clk);
      obs = observe(); n_checks++;
      if (obs !== idle_snap(1'b1)) begin n_fail++; $display("FAIL post_reset_idle: got %h want %h", obs, idle_snap(1'b1)); end
   endtask

   task automatic test_write();
      logic [31:0] prog [5] = '{32'h4000_0005, 32'h5000_0000, 32'h1000_0073, 32'h5000_0001, 32'h1000_000C};
      snap_t obs, e;
      foreach (prog[p]) begin
         issue(prog[p]);
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); obs = observe(); n_checks++;
            if (obs !== e) begin n_fail++; $display("FAIL write[%0d]: got %h want %h", p, obs, e); end
            @(negedge clk);
         end
      end
   endtask

   task automatic test_read();
      logic [31:0] prog [3] = '{32'h2000_0029, 32'h2000_00F0, 32'h2000_000F};
      snap_t obs, e;
      foreach (prog[p]) begin
         issue(prog[p]);
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); obs = observe(); n_checks++;
            if (obs !== e) begin n_fail++; $display("FAIL read[%0d]: got %h want %h", p, obs, e); end
            @(negedge clk);
         end
      end
   endtask

   task automatic test_mac();
      logic [31:0] prog [4] = '{32'h3000_00A1, 32'h3000_00FF, 32'h3000_00FC, 32'h3000_0038};
      snap_t obs, e;
      foreach (prog[p]) begin
         issue(prog[p]);
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); obs = observe(); n_checks++;
            if (obs !== e) begin n_fail++; $display("FAIL mac[%0d]: got %h want %h", p, obs, e); end
            @(negedge clk);
         end
      end
   endtask

   task automatic test_illegal_held();
      snap_t obs, e;
      instruction = 32'hF000_0000;
      instr_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (i == 2) instr_valid = 1'b0;
         e = idle_snap(1'b1); e.err = (i < 3);
         obs = observe(); n_checks++;
         if (obs !== e) begin n_fail++; $display("FAIL illegal_held[%0d]: got %h want %h", i, obs, e); end
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_write();
      snap_t obs, e;
      issue(32'h4000_000A);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); obs = observe(); n_checks++;
         if (obs !== e) begin n_fail++; $display("FAIL conf_t10: got %h want %h", obs, e); end
         @(negedge clk);
      end
      instruction = 32'h1000_0073;
      instr_valid = 1'b1;
      @(negedge clk);
      instr_valid = 1'b0;
      n_checks++;
      if ({IN1_WL[7], IN0_WL[7], instr_ready} !== 3'b000) begin
         n_fail++; $display("FAIL midwr_active: got %b want 000", {IN1_WL[7], IN0_WL[7], instr_ready});
      end
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      obs = observe(); n_checks++;
      if (obs !== idle_snap(1'b1)) begin n_fail++; $display("FAIL midwr_abort: got %h want %h", obs, idle_snap(1'b1)); end
      @(negedge clk);
      rst = 1'b0;
      m_t = 0; m_v = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         obs = observe(); n_checks++;
         if (obs !== idle_snap(1'b1)) begin n_fail++; $display("FAIL midwr_quiet[%0d]: got %h want %h", i, obs, idle_snap(1'b1)); end
      end
   endtask

   task automatic test_random();
      snap_t obs, e;
      logic [31:0] ins;
      logic [19:0] junk;
      logic [3:0]  a, b;
      for (int n = 0; n < 60; n++) begin
         junk = 20'($urandom);
         a = 4'($urandom); b = 4'($urandom);
         case ($urandom_range(0, 9))
            0:       ins = {4'h0, junk, b, a};
            1:       ins = {4'h4, junk, 8'($urandom_range(0, 6))};
            2:       ins = {4'h5, junk, 6'($urandom), 2'($urandom_range(0, 1))};
            3, 4:    ins = {4'h1, junk, b, a};
            5, 6:    ins = {4'h2, junk, b, a};
            7, 8:    ins = {4'h3, junk, b, a};
            default: ins = {4'($urandom_range(6, 15)), junk, b, a};
         endcase
         issue(ins);
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); obs = observe(); n_checks++;
            if (obs !== e) begin n_fail++; $display("FAIL random[%0d] ins %h: got %h want %h", n, ins, obs, e); end
            @(negedge clk);
         end
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_mac();
      test_illegal_held();
      test_reset_mid_write();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached with %0d checks done", n_checks);
      $fatal(1, "watchdog");
   end

endmodule
